bcd_e3_seq: RTL and testbench

- Multi-digit BCD-to-Excess-3 conversion sequencer.
- Takes a packed DIGITS-wide BCD word and time-shares one external combinational `bcdToE3` converter instance.
- Presents one digit per cycle to the converter, collects the results, flags invalid digits, then presents the packed Excess-3 word with a start/busy/done handshake.
- Sits between a controlling FSM or testbench and the shared converter.

---
 rtl/bcd_e3_seq.sv | 122 ++++++++++++
 tb/tb_bcd_e3_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_e3_seq.sv
// Multi-digit BCD-to-Excess-3 sequencer: feeds one latched digit per cycle to a
// shared external converter and packs the returned digits into one word.
module bcd_e3_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [3:0]            conv_in,
    input  logic [3:0]            conv_out,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   e3_out,
    output logic                  err
);

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [DIGITS-1:0][3:0]   digits_q;
    logic [DIGITS-1:0][3:0]   work_q;
    logic [DIGITS-1:0][3:0]   work_d;
    logic [IW-1:0]            idx_q;
    logic                     err_flag_q;
    logic                     busy_q;
    logic                     done_q;
    logic [4*DIGITS-1:0]      e3_q;
    logic                     err_q;

    logic [3:0]               cur_digit_s;
    logic                     digit_bad_s;
    logic [3:0]               slot_s;

    assign cur_digit_s = digits_q[idx_q];
    assign digit_bad_s = (cur_digit_s > 4'd9);
    // Invalid digits occupy their slot as zero rather than whatever the converter returns.
    assign slot_s      = digit_bad_s ? 4'h0 : conv_out;

    // Work register with the current slot filled in; also the value committed on the last digit.
    always_comb begin
        work_d         = work_q;
        work_d[idx_q]  = slot_s;
    end

    // Converter input is only driven with a live digit while converting.
    always_comb begin
        conv_in = 4'h0;
        if (state_q == CONV) begin
            conv_in = cur_digit_s;
        end else begin
            conv_in = 4'h0;
        end
    end

    // Sequencer state, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            digits_q   <= '0;
            work_q     <= '0;
            idx_q      <= '0;
            err_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            e3_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        digits_q   <= bcd_in;
                        work_q     <= '0;
                        err_flag_q <= 1'b0;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= CONV;
                    end else begin
                        busy_q     <= 1'b0;
                    end
                end
                CONV: begin
                    work_q     <= work_d;
                    err_flag_q <= err_flag_q | digit_bad_s;
                    if (idx_q == LAST_IDX) begin
                        e3_q    <= work_d;
                        err_q   <= err_flag_q | digit_bad_s;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign e3_out = e3_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_e3_seq.sv
// Directed bench for bcd_e3_seq (DIGITS=4) with a behavioural add-3 converter model.
module tb_bcd_e3_seq;

    localparam int DIGITS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   bcd_in;
    logic [3:0]    conv_in;
    logic [3:0]    conv_out;
    logic          busy;
    logic          done;
    logic [15:0]   e3_out;
    logic          err;

    int total = 0;
    int bad   = 0;

    bcd_e3_seq #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bcd_in   (bcd_in),
        .conv_in  (conv_in),
        .conv_out (conv_out),
        .busy     (busy),
        .done     (done),
        .e3_out   (e3_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Shared converter: add 3 for valid digits, a recognisable junk value otherwise.
    assign conv_out = (conv_in <= 4'd9) ? (conv_in + 4'd3) : 4'hE;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] e3;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] b);
        logic [15:0] r;
        logic        e;
        logic [3:0]  d;
        r = 16'h0;
        e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = b[4*i +: 4];
            if (d > 4'd9) begin
                e = 1'b1;
            end else begin
                r[4*i +: 4] = d + 4'd3;
            end
        end
        return {e, r};
    endfunction

    // One full conversion from IDLE, checking the per-cycle digit feed and the result.
    task automatic run_conv(input logic [15:0] b, input logic [15:0] exp_e3, input logic exp_err);
        @(negedge clk);
        bcd_in = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = ~b;
        for (int i = 0; i < DIGITS; i++) begin
            chk("busy_conv", {31'd0, busy}, 32'd1);
            chk("conv_in", {28'd0, conv_in}, {28'd0, b[4*i +: 4]});
            chk("done_early", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("conv_in_done", {28'd0, conv_in}, 32'd0);
        chk("e3_out", {16'd0, e3_out}, {16'd0, exp_e3});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("e3_hold", {16'd0, e3_out}, {16'd0, exp_e3});
    endtask

    initial begin
        logic [16:0] m;
        logic [15:0] v;
        logic [15:0] hist[32];

        vecs[0] = '{16'h1234, 16'h4567, 1'b0};
        vecs[1] = '{16'h9090, 16'hC3C3, 1'b0};
        vecs[2] = '{16'h0000, 16'h3333, 1'b0};
        vecs[3] = '{16'h12A4, 16'h4507, 1'b1};
        vecs[4] = '{16'h5678, 16'h89AB, 1'b0};
        vecs[5] = '{16'h9999, 16'hCCCC, 1'b0};
        vecs[6] = '{16'h7FB0, 16'hA003, 1'b1};
        vecs[7] = '{16'h0987, 16'h3CBA, 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_e3", {16'd0, e3_out}, 32'd0);
        chk("rst_conv_in", {28'd0, conv_in}, 32'd0);

        for (int k = 0; k < 8; k++) begin
            run_conv(vecs[k].bcd, vecs[k].e3, vecs[k].err);
        end

        // start held high: acceptance only from IDLE, every 6 cycles.
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                chk("cont_busy", {31'd0, busy}, {31'd0, ((k % 6) >= 1 && (k % 6) <= 4)});
                chk("cont_done", {31'd0, done}, {31'd0, ((k % 6) == 5)});
            end
            if ((k % 6) == 5) begin
                m = model(hist[k - 5]);
                chk("cont_e3", {16'd0, e3_out}, {16'd0, m[15:0]});
                chk("cont_err", {31'd0, err}, {31'd0, m[16]});
            end
            v = {4'((k + 3) % 10), 4'((k + 2) % 10), 4'((k + 1) % 10), 4'(k % 10)};
            hist[k] = v;
            bcd_in  = v;
            start   = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);

        // Reset on the second CONV cycle aborts the conversion.
        bcd_in = 16'h4321;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_e3", {16'd0, e3_out}, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        chk("abort_conv_in", {28'd0, conv_in}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_conv(16'h0987, 16'h3CBA, 1'b0);

        // rst and start on the same edge: reset wins.
        @(negedge clk);
        rst    = 1'b1;
        start  = 1'b1;
        bcd_in = 16'h1111;
        @(negedge clk);
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_e3", {16'd0, e3_out}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_start_idle", {31'd0, busy}, 32'd0);
            chk("rst_start_conv_in", {28'd0, conv_in}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
